// File: rtl/ahb_pkg.sv
// Shared AHB encodings plus the data-phase select and error-FSM types used by
// the slave mux and its default slave.
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_ROM,
        SEL_SRAM,
        SEL_DMA,
        SEL_BRIDGE,
        SEL_DEFAULT
    } dsel_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ERR1,
        ST_ERR2
    } err_state_e;

    // Address-phase decode: active transfers go to the highest-priority select,
    // or to the internal default slave when nothing claims the address.
    function automatic dsel_e decode_sel(logic [1:0] htrans, logic rom, logic sram,
                                         logic dma, logic bridge);
        if (!(htrans == HTRANS_NONSEQ || htrans == HTRANS_SEQ)) return SEL_NONE;
        if (rom)    return SEL_ROM;
        if (sram)   return SEL_SRAM;
        if (dma)    return SEL_DMA;
        if (bridge) return SEL_BRIDGE;
        return SEL_DEFAULT;
    endfunction

endpackage

// File: rtl/ahb_default_slave.sv
// Two-cycle ERROR sequencer for unmapped accesses, plus a watchdog that forces
// the same ERROR when a selected slave stalls for too long.
module ahb_default_slave
    import ahb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic capture_default,
    input  logic slave_stall,
    output logic err_active,
    output logic err_hready,
    output logic timeout_irq
);

    localparam bit               WD_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

    err_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             expire;

    // Fires on the stalled cycle that completes the TIMEOUT_CYCLES-th stall.
    assign expire = WD_EN && slave_stall && (cnt_q == LIMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (expire || capture_default) state_d = ST_ERR1;
            ST_ERR1: state_d = ST_ERR2;
            ST_ERR2: state_d = capture_default ? ST_ERR1 : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        err_active = (state_q != ST_IDLE);
        err_hready = (state_q == ST_ERR2);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            timeout_irq <= 1'b0;
        end else begin
            timeout_irq <= expire;
            if (!slave_stall || expire) cnt_q <= '0;
            else if (WD_EN)             cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/ahb_slave_mux.sv
// AHB response mux: registers the address-phase select and steers the chosen
// slave's data-phase response back to the master.
module ahb_slave_mux
    import ahb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic [1:0]  HTRANS,
    input  logic        ahb_rom_sel,
    input  logic        ahb_sram_sel,
    input  logic        ahb_dma_sel,
    input  logic        apb_bridge_sel,
    input  logic [31:0] rom_HRDATA,
    input  logic [31:0] sram_HRDATA,
    input  logic [31:0] dma_HRDATA,
    input  logic [31:0] bridge_HRDATA,
    input  logic        rom_HREADYOUT,
    input  logic        sram_HREADYOUT,
    input  logic        dma_HREADYOUT,
    input  logic        bridge_HREADYOUT,
    input  logic        rom_HRESP,
    input  logic        sram_HRESP,
    input  logic        dma_HRESP,
    input  logic        bridge_HRESP,
    output logic [31:0] HRDATA,
    output logic        HREADY,
    output logic        HRESP,
    output logic        timeout_irq
);

    dsel_e sel_q, sel_d;
    logic  err_active, err_hready, slave_stall, capture_default;

    assign sel_d = decode_sel(HTRANS, ahb_rom_sel, ahb_sram_sel, ahb_dma_sel, apb_bridge_sel);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn)    sel_q <= SEL_NONE;
        else if (HREADY) sel_q <= sel_d;
    end

    // An ERROR sequence overrides whatever slave is still registered.
    always_comb begin
        HRDATA = '0;
        HREADY = 1'b1;
        HRESP  = HRESP_OKAY;
        if (err_active) begin
            HREADY = err_hready;
            HRESP  = HRESP_ERROR;
        end else begin
            case (sel_q)
                SEL_ROM:    begin HRDATA = rom_HRDATA;    HREADY = rom_HREADYOUT;    HRESP = rom_HRESP;    end
                SEL_SRAM:   begin HRDATA = sram_HRDATA;   HREADY = sram_HREADYOUT;   HRESP = sram_HRESP;   end
                SEL_DMA:    begin HRDATA = dma_HRDATA;    HREADY = dma_HREADYOUT;    HRESP = dma_HRESP;    end
                SEL_BRIDGE: begin HRDATA = bridge_HRDATA; HREADY = bridge_HREADYOUT; HRESP = bridge_HRESP; end
                default: ;
            endcase
        end
    end

    assign slave_stall     = !err_active && !HREADY &&
                             (sel_q inside {SEL_ROM, SEL_SRAM, SEL_DMA, SEL_BRIDGE});
    assign capture_default = HREADY && (sel_d == SEL_DEFAULT);

    ahb_default_slave #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CNT_W)
    ) u_default_slave (
        .clk             (HCLK),
        .rst_n           (HRESETn),
        .capture_default (capture_default),
        .slave_stall     (slave_stall),
        .err_active      (err_active),
        .err_hready      (err_hready),
        .timeout_irq     (timeout_irq)
    );

endmodule

// File: tb/tb_ahb_slave_mux.sv
// Bench for ahb_slave_mux: directed scenarios plus random traffic, all checked
// each cycle against a transaction-level model of the response rules.
module tb_ahb_slave_mux;

    localparam int TO = 4;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic [1:0]  HTRANS = 2'b00;
    logic        s_sel   [4];
    logic [31:0] s_rdata [4];
    logic        s_rdy   [4];
    logic        s_resp  [4];
    logic [31:0] HRDATA;
    logic        HREADY, HRESP, timeout_irq;

    int checks = 0;
    int errors = 0;

    always #5 HCLK = ~HCLK;

    ahb_slave_mux #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HTRANS(HTRANS),
        .ahb_rom_sel(s_sel[0]), .ahb_sram_sel(s_sel[1]),
        .ahb_dma_sel(s_sel[2]), .apb_bridge_sel(s_sel[3]),
        .rom_HRDATA(s_rdata[0]), .sram_HRDATA(s_rdata[1]),
        .dma_HRDATA(s_rdata[2]), .bridge_HRDATA(s_rdata[3]),
        .rom_HREADYOUT(s_rdy[0]), .sram_HREADYOUT(s_rdy[1]),
        .dma_HREADYOUT(s_rdy[2]), .bridge_HREADYOUT(s_rdy[3]),
        .rom_HRESP(s_resp[0]), .sram_HRESP(s_resp[1]),
        .dma_HRESP(s_resp[2]), .bridge_HRESP(s_resp[3]),
        .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP), .timeout_irq(timeout_irq)
    );

    // Model state: m_sel is the data-phase target (0 none, 1..4 slaves, 5 unmapped),
    // m_err counts remaining forced ERROR cycles, m_run counts consecutive stalls.
    int   m_sel = 0;
    int   m_err = 0;
    int   m_run = 0;
    logic m_irq = 1'b0;
    logic [31:0] exp_hrdata;
    logic        exp_hready, exp_hresp;

    function automatic int decode();
        if (HTRANS[1] == 1'b0) return 0;
        for (int k = 0; k < 4; k++) if (s_sel[k]) return k + 1;
        return 5;
    endfunction

    always_comb begin
        exp_hrdata = '0;
        exp_hready = 1'b1;
        exp_hresp  = 1'b0;
        if (m_err == 2) begin
            exp_hready = 1'b0;
            exp_hresp  = 1'b1;
        end else if (m_err == 1) begin
            exp_hresp = 1'b1;
        end else if (m_sel >= 1 && m_sel <= 4) begin
            exp_hrdata = s_rdata[m_sel-1];
            exp_hready = s_rdy[m_sel-1];
            exp_hresp  = s_resp[m_sel-1];
        end
    end

    always @(posedge HCLK or negedge HRESETn) begin : model
        int nsel;
        bit stalled, expired;
        if (!HRESETn) begin
            m_sel <= 0; m_err <= 0; m_run <= 0; m_irq <= 1'b0;
        end else begin
            stalled = (m_err == 0) && (m_sel >= 1) && (m_sel <= 4) && !exp_hready;
            expired = stalled && (m_run + 1 == TO);
            m_irq  <= expired;
            m_run  <= (stalled && !expired) ? m_run + 1 : 0;
            if (m_err == 2) begin
                m_err <= 1;
            end else if (expired) begin
                m_err <= 2;
            end else if (exp_hready) begin
                nsel = decode();
                m_sel <= nsel;
                m_err <= (nsel == 5) ? 2 : 0;
            end
        end
    end

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge HCLK) begin
        chk("model_hrdata", HRDATA, exp_hrdata);
        chk("model_hready", 32'(HREADY), 32'(exp_hready));
        chk("model_hresp",  32'(HRESP),  32'(exp_hresp));
        chk("model_irq",    32'(timeout_irq), 32'(m_irq));
    end

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic drive(logic [1:0] tr, logic [3:0] sel);
        HTRANS = tr;
        for (int k = 0; k < 4; k++) s_sel[k] = sel[k];
    endtask

    task automatic expect_out(string nm, logic [31:0] d, logic r, logic e, logic irq);
        @(negedge HCLK);
        chk({nm, "_hrdata"}, HRDATA, d);
        chk({nm, "_hready"}, 32'(HREADY), 32'(r));
        chk({nm, "_hresp"},  32'(HRESP),  32'(e));
        chk({nm, "_irq"},    32'(timeout_irq), 32'(irq));
    endtask

    initial begin
        for (int k = 0; k < 4; k++) begin
            s_sel[k]   = 1'b0;
            s_rdata[k] = 32'hA000_0000 + 32'(k);
            s_rdy[k]   = 1'b1;
            s_resp[k]  = 1'b0;
        end
        expect_out("reset", 32'h0, 1'b1, 1'b0, 1'b0);
        step();
        HRESETn = 1'b1;

        // Zero-wait SRAM read
        drive(2'b10, 4'b0010);
        s_rdata[1] = 32'hDEAD_BEEF;
        step();
        drive(2'b00, 4'b0000);
        expect_out("sram_rd", 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0);
        step();

        // Unmapped access -> two-cycle ERROR
        drive(2'b10, 4'b0000);
        step();
        drive(2'b00, 4'b0000);
        expect_out("unmapped_c1", 32'h0, 1'b0, 1'b1, 1'b0);
        step();
        expect_out("unmapped_c2", 32'h0, 1'b1, 1'b1, 1'b0);
        step();
        expect_out("unmapped_done", 32'h0, 1'b1, 1'b0, 1'b0);
        step();

        // Stalled bridge while rom_sel toggles
        drive(2'b10, 4'b1000);
        s_rdata[3] = 32'hB0B0_0003;
        step();
        s_rdy[3] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(2'b10, (i % 2 == 0) ? 4'b0001 : 4'b0000);
            expect_out("bridge_stall", 32'hB0B0_0003, 1'b0, 1'b0, 1'b0);
            step();
        end
        s_rdy[3] = 1'b1;
        drive(2'b10, 4'b0001);
        expect_out("bridge_release", 32'hB0B0_0003, 1'b1, 1'b0, 1'b0);
        step();
        drive(2'b00, 4'b0000);
        expect_out("rom_after_stall", 32'hA000_0000, 1'b1, 1'b0, 1'b0);
        step();

        // Watchdog on a stuck DMA slave
        drive(2'b10, 4'b0100);
        step();
        s_rdy[2] = 1'b0;
        drive(2'b00, 4'b0000);
        for (int i = 0; i < TO; i++) begin
            expect_out("wd_stall", 32'hA000_0002, 1'b0, 1'b0, 1'b0);
            step();
        end
        expect_out("wd_err1", 32'h0, 1'b0, 1'b1, 1'b1);
        step();
        expect_out("wd_err2", 32'h0, 1'b1, 1'b1, 1'b0);
        step();
        expect_out("wd_idle", 32'h0, 1'b1, 1'b0, 1'b0);
        s_rdy[2] = 1'b1;
        step();

        // IDLE transfer with rom_sel asserted
        drive(2'b00, 4'b0001);
        step();
        s_rdy[0] = 1'b0;
        drive(2'b00, 4'b0000);
        expect_out("idle_xfer", 32'h0, 1'b1, 1'b0, 1'b0);
        s_rdy[0] = 1'b1;
        step();

        // Reset asserted during ERR1
        drive(2'b10, 4'b0000);
        step();
        drive(2'b00, 4'b0000);
        expect_out("err1_pre_reset", 32'h0, 1'b0, 1'b1, 1'b0);
        #2 HRESETn = 1'b0;
        #1;
        chk("async_rst_hready", 32'(HREADY), 32'h1);
        chk("async_rst_hresp",  32'(HRESP),  32'h0);
        chk("async_rst_hrdata", HRDATA,      32'h0);
        chk("async_rst_irq",    32'(timeout_irq), 32'h0);
        step();
        step();
        HRESETn = 1'b1;
        drive(2'b10, 4'b0010);
        s_rdata[1] = 32'h1234_5678;
        step();
        drive(2'b00, 4'b0000);
        expect_out("sram_after_reset", 32'h1234_5678, 1'b1, 1'b0, 1'b0);
        step();

        // Random traffic, with periodic stuck windows to provoke timeouts
        for (int i = 0; i < 600; i++) begin
            HTRANS = 2'($urandom_range(0, 3));
            for (int k = 0; k < 4; k++) begin
                s_sel[k]   = ($urandom_range(0, 3) == 0);
                s_rdata[k] = $urandom;
                s_rdy[k]   = ((i % 50) >= 42) ? 1'b0 : ($urandom_range(0, 9) < 6);
                s_resp[k]  = ($urandom_range(0, 7) == 0);
            end
            step();
        end

        @(negedge HCLK);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
